// File: rtl/register_pkg.sv
// register_pkg: shared width helpers and default-size types for register_fifo
package register_pkg;
  function automatic int clog2_ceil(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) r++;
    return r;
  endfunction
  function automatic int ptr_width(input int depth);
    return (depth > 2) ? clog2_ceil(depth) : 1;
  endfunction
  localparam int DEF_DEPTH = 4;
  localparam int DEF_PTR_W = ptr_width(DEF_DEPTH);
  localparam int DEF_CNT_W = clog2_ceil(DEF_DEPTH + 1);
  typedef logic [DEF_PTR_W-1:0] ptr_t;
  typedef logic [DEF_CNT_W-1:0] cnt_t;
endpackage

// File: rtl/register_fifo_ptr.sv
// register_fifo_ptr: wrapping index 0..DEPTH-1 advancing on inc; ports clk, rst_n (sync active-low), clear (REGISTER_FIFO_CLEAR_EN only), inc, ptr
module register_fifo_ptr
  import register_pkg::*;
#(
  parameter int PTR_W = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef REGISTER_FIFO_CLEAR_EN
  input  logic             clear,
`endif
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);
  logic flush;
`ifdef REGISTER_FIFO_CLEAR_EN
  assign flush = clear;
`else
  assign flush = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!rst_n || flush) ptr <= '0;
    else if (inc) ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/register_fifo.sv
// register_fifo: first-word fall-through valid/ready FIFO of WIDTH-bit registers with count/full/empty and sticky overflow; ports clk, rst_n (sync active-low), clear (REGISTER_FIFO_CLEAR_EN only), in_data/in_valid/in_ready, out_data/out_valid/out_ready, count, full, empty, overflow
module register_fifo
  import register_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CNT_W = clog2_ceil(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef REGISTER_FIFO_CLEAR_EN
  input  logic             clear,
`endif
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow
);
  logic push, pop, flush;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
`ifdef REGISTER_FIFO_CLEAR_EN
  assign flush = clear;
`else
  assign flush = 1'b0;
`endif
  assign full      = count == CNT_W'(DEPTH);
  assign empty     = count == '0;
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = empty ? '0 : mem[rd_ptr];
  register_fifo_ptr #(.PTR_W(PTR_W), .DEPTH(DEPTH)) u_wr (
    .clk(clk),
    .rst_n(rst_n),
`ifdef REGISTER_FIFO_CLEAR_EN
    .clear(clear),
`endif
    .inc(push),
    .ptr(wr_ptr)
  );
  register_fifo_ptr #(.PTR_W(PTR_W), .DEPTH(DEPTH)) u_rd (
    .clk(clk),
    .rst_n(rst_n),
`ifdef REGISTER_FIFO_CLEAR_EN
    .clear(clear),
`endif
    .inc(pop),
    .ptr(rd_ptr)
  );
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [WIDTH-1:0] q;
    always_ff @(posedge clk)
      if (push && wr_ptr == PTR_W'(i)) q <= in_data;
    assign mem[i] = q;
  end
  always_ff @(posedge clk)
    if (!rst_n || flush) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count    <= count + CNT_W'(push) - CNT_W'(pop);
      overflow <= overflow | (in_valid & full);
    end
endmodule
